// File: rtl/set_counter_grid.sv
// Grid-point set counter: scans every lattice point (x,y) in 1..GRID one per clock
// and counts the points that satisfy the selected set expression over circles A, B, C.
module set_counter_grid #(
    parameter int GRID  = 8,
    parameter int CW    = 4,
    parameter int RW    = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [6*CW-1:0]   central,
    input  logic [3*RW-1:0]   radius,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              valid,
    output logic [CNT_W-1:0]  candidate
);

    localparam int DW = CW + 1;
    localparam int SW = 2 * DW + 1;
    localparam int MW = (SW > 2 * RW) ? SW : 2 * RW;
    localparam logic [CW-1:0] GRID_X = CW'(GRID);
    localparam logic [CW-1:0] ONE_X  = CW'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     x;
    logic [CW-1:0]     y;
    logic [6*CW-1:0]   job_central;
    logic [3*RW-1:0]   job_radius;
    logic [1:0]        job_mode;
    logic              in_a;
    logic              in_b;
    logic              in_c;
    logic              hit;

    // Exact distance test; signed differences are folded to magnitudes so the
    // squares stay unsigned and wide enough that nothing can overflow.
    function automatic logic in_circle(
        input logic [CW-1:0] px,
        input logic [CW-1:0] py,
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy,
        input logic [RW-1:0] r
    );
        logic signed [DW-1:0] dx;
        logic signed [DW-1:0] dy;
        logic [DW-1:0]        ax;
        logic [DW-1:0]        ay;
        logic [SW-1:0]        dist_sq;
        logic [2*RW-1:0]      r_sq;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({1'b0, cy});
        ax = dx[DW-1] ? DW'(-dx) : DW'(dx);
        ay = dy[DW-1] ? DW'(-dy) : DW'(dy);
        dist_sq = SW'(ax) * SW'(ax) + SW'(ay) * SW'(ay);
        r_sq = (2*RW)'(r) * (2*RW)'(r);
        return MW'(dist_sq) <= MW'(r_sq);
    endfunction

    always_comb begin
        in_a = in_circle(x, y, job_central[6*CW-1 -: CW], job_central[5*CW-1 -: CW],
                         job_radius[3*RW-1 -: RW]);
        in_b = in_circle(x, y, job_central[4*CW-1 -: CW], job_central[3*CW-1 -: CW],
                         job_radius[2*RW-1 -: RW]);
        in_c = in_circle(x, y, job_central[2*CW-1 -: CW], job_central[CW-1 -: CW],
                         job_radius[RW-1 -: RW]);
        case (job_mode)
            2'b00:   hit = in_a;
            2'b01:   hit = in_a & in_b;
            2'b10:   hit = in_a ^ in_b;
            default: hit = ({1'b0, in_a} + {1'b0, in_b} + {1'b0, in_c}) == 2'd2;
        endcase
    end

    // Job FSM: capture on accept, one point per clock, one-cycle DONE pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            valid       <= 1'b0;
            candidate   <= '0;
            x           <= ONE_X;
            y           <= ONE_X;
            job_central <= '0;
            job_radius  <= '0;
            job_mode    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        job_central <= central;
                        job_radius  <= radius;
                        job_mode    <= mode;
                        candidate   <= '0;
                        x           <= ONE_X;
                        y           <= ONE_X;
                        busy        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        candidate <= candidate + CNT_W'(1);
                    end
                    if (x == GRID_X) begin
                        x <= ONE_X;
                        if (y == GRID_X) begin
                            y     <= ONE_X;
                            valid <= 1'b1;
                            state <= DONE;
                        end else begin
                            y <= y + ONE_X;
                        end
                    end else begin
                        x <= x + ONE_X;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
